step_dir_gen: RTL and testbench

Step/direction pulse generator: the transmitting end of the team's step/dir up-down counting interface. It accepts a move request (direction plus step count) over a valid/ready handshake and emits a `dir` level and timed `step` pulses. The up-down position counter downstream counts +1 per step with `dir`=1 and -1 with `dir`=0. A mirror position register tracks what that counter holds.

---
 rtl/step_dir_pkg.sv | 24 ++
 rtl/step_phase_timer.sv | 22 ++
 rtl/step_dir_gen.sv | 127 ++++++++++++
 tb/tb_step_dir_gen.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/step_dir_pkg.sv
// Shared types and constants for the step/dir pulse generator.
package step_dir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } sd_state_t;

  localparam int SETUP_CYC_DEF = 1;
  localparam int HIGH_CYC_DEF  = 2;
  localparam int LOW_CYC_DEF   = 2;

  // Phase timer holds length-1, so the widest phase length must fit.
  function automatic int phase_w(input int s, input int h, input int l);
    int m;
    m = s;
    if (h > m) m = h;
    if (l > m) m = l;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/step_phase_timer.sv
// Loadable down-counter; expired flags the last cycle of the loaded phase.
module step_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)               cnt <= '0;
    else if (load)         cnt <= value;
    else if (cnt != '0)    cnt <= cnt - W'(1);
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/step_dir_gen.sv
// Step/direction pulse generator with mirror position of the downstream counter.
module step_dir_gen
  import step_dir_pkg::*;
#(
  parameter int POS_W     = 3,
  parameter int STEP_W    = 8,
  parameter int SETUP_CYC = SETUP_CYC_DEF,
  parameter int HIGH_CYC  = HIGH_CYC_DEF,
  parameter int LOW_CYC   = LOW_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_dir,
  input  logic [STEP_W-1:0] req_steps,
  input  logic              abort,
  output logic              step,
  output logic              dir,
  output logic              busy,
  output logic              done,
  output logic [POS_W-1:0]  pos
);

  localparam int CW = phase_w(SETUP_CYC, HIGH_CYC, LOW_CYC);
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] HIGH_LD  = CW'(HIGH_CYC - 1);
  localparam logic [CW-1:0] LOW_LD   = CW'(LOW_CYC - 1);

  sd_state_t         state;
  logic [STEP_W-1:0] remaining;
  logic              abort_pend;
  logic              tmr_load;
  logic [CW-1:0]     tmr_value;
  logic              expired;

  assign req_ready = (state == IDLE) && !rst;

  // Last pulse or a pending abort ends the move at the end of LOW.
  logic low_finish;
  assign low_finish = (remaining == '0) || abort_pend;

  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = SETUP_LD;
    case (state)
      IDLE:  begin tmr_load = req_valid && (req_steps != '0); tmr_value = SETUP_LD; end
      SETUP: begin tmr_load = expired && !abort;               tmr_value = HIGH_LD;  end
      HIGH:  begin tmr_load = expired;                         tmr_value = LOW_LD;   end
      LOW:   begin tmr_load = expired && !abort && !low_finish; tmr_value = HIGH_LD; end
      default: ;
    endcase
  end

  step_phase_timer #(.W(CW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .value   (tmr_value),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      step       <= 1'b0;
      dir        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pos        <= '0;
      remaining  <= '0;
      abort_pend <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_steps == '0) begin
              done <= 1'b1;
            end else begin
              dir       <= req_dir;
              remaining <= req_steps;
              state     <= SETUP;
              busy      <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (abort) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b1;
            abort_pend <= 1'b0;
          end else if (expired) begin
            state <= HIGH;
            step  <= 1'b1;
            pos   <= dir ? pos + POS_W'(1) : pos - POS_W'(1);
            if (remaining != '0) remaining <= remaining - STEP_W'(1);
          end
        end
        HIGH: begin
          // Pulse width is never shortened; the abort is deferred to LOW's end.
          if (abort) abort_pend <= 1'b1;
          if (expired) begin
            state <= LOW;
            step  <= 1'b0;
          end
        end
        LOW: begin
          if (abort || (expired && low_finish)) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b1;
            abort_pend <= 1'b0;
          end else if (expired) begin
            state <= HIGH;
            step  <= 1'b1;
            pos   <= dir ? pos + POS_W'(1) : pos - POS_W'(1);
            if (remaining != '0) remaining <= remaining - STEP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_step_dir_gen.sv
// Self-checking bench for step_dir_gen: vector table, hand sequences, random moves.
module tb_step_dir_gen;

  localparam int S = 1;
  localparam int H = 2;
  localparam int L = 2;
  localparam int P = H + L;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_dir;
  logic [7:0] req_steps;
  logic       abort;
  logic       step;
  logic       dir;
  logic       busy;
  logic       done;
  logic [2:0] pos;

  int tests = 0;
  int fails = 0;

  logic [2:0] pos_m = 3'd0;
  logic       dir_m = 1'b0;

  always #5 clk = ~clk;

  step_dir_gen dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_dir   (req_dir),
    .req_steps (req_steps),
    .abort     (abort),
    .step      (step),
    .dir       (dir),
    .busy      (busy),
    .done      (done),
    .pos       (pos)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Pulse count and done cycle from the move's timing rules.
  task automatic plan(input int n, input int a, output int ne, output int e);
    int r, k, off;
    if (n == 0) begin ne = 0; e = 0; end
    else begin
      ne = n;
      e  = S + n * P;
      if (a >= 0 && a < e) begin
        if (a < S) begin ne = 0; e = a + 1; end
        else begin
          r = a - S; k = r / P; off = r % P;
          ne = k + 1;
          e  = (off < H) ? S + (k + 1) * P : a + 1;
        end
      end
    end
  endtask

  task automatic do_move(input logic d, input int n, input int a, output int obs_done);
    int ne, e, started;
    logic [2:0] p0, pexp;
    logic d_exp, s_exp;
    plan(n, a, ne, e);
    p0 = pos_m;
    d_exp = (n > 0) ? d : dir_m;
    obs_done = -1;
    req_valid = 1'b1; req_dir = d; req_steps = 8'(n);
    for (int t = 0; t <= e; t++) begin
      @(posedge clk); #1;
      abort = (t == a);
      if (t > 0 && t < e) begin
        req_valid = 1'($urandom_range(0, 1));
        req_dir   = 1'($urandom_range(0, 1));
        req_steps = 8'($urandom_range(0, 255));
      end else req_valid = 1'b0;
      @(negedge clk);
      started = (t >= S) ? (t - S) / P + 1 : 0;
      if (started > ne) started = ne;
      s_exp = (t >= S) && (t < e) && ((t - S) / P < ne) && ((t - S) % P < H);
      pexp = d_exp ? p0 + 3'(started) : p0 - 3'(started);
      chk($sformatf("step n=%0d t=%0d", n, t), 32'(step), 32'(s_exp));
      chk($sformatf("busy n=%0d t=%0d", n, t), 32'(busy), 32'(t < e));
      chk($sformatf("done n=%0d t=%0d", n, t), 32'(done), 32'(t == e));
      chk($sformatf("pos n=%0d t=%0d", n, t), 32'(pos), 32'(pexp));
      chk($sformatf("dir n=%0d t=%0d", n, t), 32'(dir), 32'(d_exp));
      chk($sformatf("ready n=%0d t=%0d", n, t), 32'(req_ready), 32'(t >= e));
      if (done === 1'b1 && obs_done < 0) obs_done = t;
    end
    abort = 1'b0;
    pos_m = d_exp ? p0 + 3'(ne) : p0 - 3'(ne);
    dir_m = d_exp;
  endtask

  typedef struct {
    logic       d;
    int         n;
    int         a;
    int         exp_done;
    logic [2:0] exp_pos;
    logic       exp_dir;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int od, n, a, e0;
    logic d;
    rst = 1'b1; req_valid = 1'b0; req_dir = 1'b0; req_steps = '0; abort = 1'b0;

    tbl[0] = '{1'b0, 1, -1,  5, 3'd7, 1'b0};
    tbl[1] = '{1'b1, 9, -1, 37, 3'd0, 1'b1};
    tbl[2] = '{1'b1, 3, -1, 13, 3'd3, 1'b1};
    tbl[3] = '{1'b0, 2, -1,  9, 3'd1, 1'b0};
    tbl[4] = '{1'b1, 0, -1,  0, 3'd1, 1'b0};
    tbl[5] = '{1'b1, 5,  5,  9, 3'd3, 1'b1};
    tbl[6] = '{1'b1, 4,  0,  1, 3'd3, 1'b1};
    tbl[7] = '{1'b0, 3,  7,  8, 3'd1, 1'b0};
    tbl[8] = '{1'b1, 2,  4,  5, 3'd2, 1'b1};

    for (int i = 0; i < 2; i++) begin
      @(posedge clk); @(negedge clk);
      chk("rst step", 32'(step), 0);
      chk("rst dir", 32'(dir), 0);
      chk("rst pos", 32'(pos), 0);
      chk("rst busy", 32'(busy), 0);
      chk("rst done", 32'(done), 0);
      chk("rst ready", 32'(req_ready), 0);
    end
    rst = 1'b0;
    #1;
    chk("ready after rst", 32'(req_ready), 1);

    for (int i = 0; i < 9; i++) begin
      do_move(tbl[i].d, tbl[i].n, tbl[i].a, od);
      chk($sformatf("vec%0d done cycle", i), 32'(od), 32'(tbl[i].exp_done));
      chk($sformatf("vec%0d final pos", i), 32'(pos), 32'(tbl[i].exp_pos));
      chk($sformatf("vec%0d final dir", i), 32'(dir), 32'(tbl[i].exp_dir));
    end

    // Reset in cycle 2 of a 4-step move cuts the pulse and suppresses done.
    req_valid = 1'b1; req_dir = 1'b1; req_steps = 8'd4;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("midrst step c1", 32'(step), 1);
    chk("midrst pos c1", 32'(pos), 32'(pos_m + 3'd1));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst step", 32'(step), 0);
    chk("midrst pos", 32'(pos), 0);
    chk("midrst dir", 32'(dir), 0);
    chk("midrst busy", 32'(busy), 0);
    chk("midrst done", 32'(done), 0);
    chk("midrst ready", 32'(req_ready), 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst no done", 32'(done), 0);
    end
    pos_m = 3'd0; dir_m = 1'b0;
    do_move(1'b1, 2, -1, od);
    chk("post-rst done cycle", 32'(od), 9);
    chk("post-rst pos", 32'(pos), 2);

    for (int i = 0; i < 25; i++) begin
      d  = 1'($urandom_range(0, 1));
      n  = $urandom_range(0, 6);
      e0 = S + n * P;
      a  = (n > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(0, e0 - 1) : -1;
      do_move(d, n, a, od);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
